// File: rtl/fetch_pkg.sv
// Shared types and widths for the instruction-fetch stage.
// Opcode field bounds are used by the FETCH_HALT_EN halt decode.
package fetch_pkg;
  localparam int INSTR_W = 21;
  localparam int PC_W    = 12;
  localparam int OPC_MSB = 19;
  localparam int OPC_LSB = 15;

  localparam logic [INSTR_W-1:0] NOP = '0;

  typedef enum logic {
    S_RUN,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic               valid;
  } if_id_t;
endpackage

// File: rtl/if_fetch_stage_if.sv
// Fetch <-> decode bundle: control from decode, IF/ID view to decode.
// master is the fetch side, slave is the decode side.
interface if_fetch_stage_if;
  import fetch_pkg::*;

  logic               stall;
  logic               flush;
  logic               branch_taken;
  logic [PC_W-1:0]    BranchAddr;
  logic [INSTR_W-1:0] Instruction;
  logic [PC_W-1:0]    PC;
  logic               valid;
  logic               halted;

  modport master (
    input  stall, flush, branch_taken, BranchAddr,
    output Instruction, PC, valid, halted
  );

  modport slave (
    output stall, flush, branch_taken, BranchAddr,
    input  Instruction, PC, valid, halted
  );
endinterface

// File: rtl/fetch_pc_gen.sv
// Next-PC select (redirect / hold / increment) and ROM address.
// The stalled address replays the pending word so imem_data stays put.
module fetch_pc_gen
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] PC_STEP = 12'd1
) (
  input  logic            stall,
  input  logic            redirect,
  input  logic            hold,
  input  logic [PC_W-1:0] pc_q,
  input  logic [PC_W-1:0] fpc_q,
  input  logic [PC_W-1:0] branch_addr,
  output logic [PC_W-1:0] pc_d,
  output logic [PC_W-1:0] imem_addr
);
  always_comb begin
    pc_d = pc_q + PC_STEP;
    if (redirect) begin
      pc_d = branch_addr;
    end else if (hold) begin
      pc_d = pc_q;
    end
  end

  assign imem_addr = stall ? fpc_q : pc_q;
endmodule

// File: rtl/if_fetch_stage.sv
// Fetch stage: PC, sync-ROM fetch tracking and IF/ID register.
// Define FETCH_HALT_EN to enable halt-on-opcode.
module if_fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0]    RESET_PC    = 12'h000,
  parameter logic [PC_W-1:0]    PC_STEP     = 12'd1,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = NOP,
  parameter logic [4:0]         HALT_OPCODE = 5'b11111
) (
  input  logic               clk,
  input  logic               rst_n,
  if_fetch_stage_if.master   f,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data
);
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  localparam if_id_t BUBBLE = '{
    instr: NOP_INSTR,
    pc:    '0,
    valid: 1'b0
  };

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] fpc_q;
  logic [PC_W-1:0] pc_d;
  logic            fvld_q;
  if_id_t          ifid_q;
  if_id_t          fetched;
  fetch_state_t    state_q;
  fetch_state_t    state_d;

  logic do_halt;
  logic do_flush;
  logic do_br;
  logic do_stall;
  logic do_run;
  logic halt_hit;

  // One-hot action select: flush > branch > stall > run; halt overrides.
  always_comb begin
    do_halt  = (state_q == S_HALT);
    do_flush = !do_halt && f.flush;
    do_br    = !do_halt && !f.flush && f.branch_taken;
    do_stall = !do_halt && !f.flush && !f.branch_taken
               && f.stall;
    do_run   = !do_halt && !f.flush && !f.branch_taken
               && !f.stall;
  end

  fetch_pc_gen #(
    .PC_STEP (PC_STEP)
  ) u_pc_gen (
    .stall       (f.stall),
    .redirect    (do_br),
    .hold        (do_halt || do_stall),
    .pc_q        (pc_q),
    .fpc_q       (fpc_q),
    .branch_addr (f.BranchAddr),
    .pc_d        (pc_d),
    .imem_addr   (imem_addr)
  );

  // A killed fetch enters IF/ID as a clean bubble, not stale ROM data.
  always_comb begin
    fetched = BUBBLE;
    if (fvld_q) begin
      fetched = '{instr: imem_data, pc: fpc_q, valid: 1'b1};
    end
  end

  assign halt_hit = HALT_EN
    && (imem_data[OPC_MSB:OPC_LSB] == HALT_OPCODE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (do_run && fvld_q && halt_hit) begin
      state_d = S_HALT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      fpc_q  <= '0;
      fvld_q <= 1'b0;
      ifid_q <= BUBBLE;
    end else begin
      unique case (1'b1)
        do_halt: begin
          if (!f.stall) ifid_q <= BUBBLE;
          fvld_q <= 1'b0;
        end
        do_flush: begin
          ifid_q <= BUBBLE;
          fpc_q  <= pc_q;
          fvld_q <= 1'b0;
          pc_q   <= pc_d;
        end
        do_br: begin
          ifid_q <= BUBBLE;
          fpc_q  <= f.BranchAddr;
          fvld_q <= 1'b0;
          pc_q   <= pc_d;
        end
        do_stall: begin
        end
        do_run: begin
          ifid_q <= fetched;
          fpc_q  <= pc_q;
          fvld_q <= 1'b1;
          pc_q   <= pc_d;
        end
        default: begin
        end
      endcase
    end
  end

  assign f.Instruction = ifid_q.instr;
  assign f.PC          = ifid_q.pc;
  assign f.valid       = ifid_q.valid;
  assign f.halted      = HALT_EN && (state_q == S_HALT);
endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage against a fetch-queue model.
// Halt scenarios run only when FETCH_HALT_EN is defined.
module tb_if_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] imem_addr, imem_addr_w;
  logic [20:0] imem_data = '0;
  logic [20:0] imem_data_w = '0;

  int n_checks = 0;
  int n_errors = 0;

  logic        rom_halt = 1'b0;
  logic [11:0] halt_at = 12'h003;

  if_fetch_stage_if fi ();
  if_fetch_stage_if fw ();

  if_fetch_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .f         (fi),
    .imem_addr (imem_addr),
    .imem_data (imem_data)
  );

  if_fetch_stage #(.RESET_PC(12'hFFE)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .f         (fw),
    .imem_addr (imem_addr_w),
    .imem_data (imem_data_w)
  );

  assign fw.stall        = 1'b0;
  assign fw.flush        = 1'b0;
  assign fw.branch_taken = 1'b0;
  assign fw.BranchAddr   = 12'h000;

  always #5 clk = ~clk;

  function automatic logic [20:0] rom_word(input logic [11:0] a);
    if (rom_halt && a == halt_at) return {1'b0, 5'b11111, 15'h0};
    return {9'h0, a};
  endfunction

  always @(posedge clk) imem_data   <= rom_word(imem_addr);
  always @(posedge clk) imem_data_w <= rom_word(imem_addr_w);

  // Reference model: next address to fetch, the one word in flight,
  // the word presented to decode, and a sticky halt flag.
  logic [11:0] m_next;
  logic [11:0] m_fly_pc;
  logic        m_fly_live;
  logic [20:0] e_instr;
  logic [11:0] e_pc;
  logic        e_valid;
  logic        m_halt;
  logic [11:0] e_addr, a_addr;

  function automatic logic [34:0] act_o();
    return {fi.Instruction, fi.PC, fi.valid, fi.halted};
  endfunction

  function automatic logic [34:0] exp_o();
    return {e_instr, e_pc, e_valid, m_halt};
  endfunction

  task automatic model_reset();
    m_next = 12'h000; m_fly_pc = 12'h000; m_fly_live = 1'b0;
    e_instr = '0; e_pc = '0; e_valid = 1'b0; m_halt = 1'b0;
  endtask

  task automatic to_decode_bubble();
    e_instr = '0; e_pc = '0; e_valid = 1'b0;
  endtask

  // Applies one cycle of inputs just after a falling edge, steps the
  // model across the rising edge and returns at the next falling edge.
  task automatic drive_cycle(input logic st, input logic fl,
                             input logic br, input logic [11:0] ba);
    logic [20:0] w;
    fi.stall = st; fi.flush = fl;
    fi.branch_taken = br; fi.BranchAddr = ba;
    #1;
    a_addr = imem_addr;
    e_addr = st ? m_fly_pc : m_next;
    @(posedge clk);
    w = rom_word(m_fly_pc);
    if (m_halt) begin
      if (!st) to_decode_bubble();
      m_fly_live = 1'b0;
    end else if (fl) begin
      to_decode_bubble();
      m_fly_pc = m_next; m_fly_live = 1'b0;
      m_next = m_next + 12'd1;
    end else if (br) begin
      to_decode_bubble();
      m_fly_pc = ba; m_fly_live = 1'b0; m_next = ba;
    end else if (!st) begin
      if (m_fly_live) begin
        e_instr = w; e_pc = m_fly_pc; e_valid = 1'b1;
      end else begin
        to_decode_bubble();
      end
`ifdef FETCH_HALT_EN
      if (m_fly_live && w[19:15] == 5'b11111) m_halt = 1'b1;
`endif
      m_fly_pc = m_next; m_fly_live = 1'b1;
      m_next = m_next + 12'd1;
    end
    @(negedge clk);
    fi.stall = 1'b0; fi.flush = 1'b0; fi.branch_taken = 1'b0;
  endtask

  task automatic do_reset();
    fi.stall = 0; fi.flush = 0; fi.branch_taken = 0;
    fi.BranchAddr = '0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    fi.stall = 0; fi.flush = 0; fi.branch_taken = 0;
    fi.BranchAddr = '0;
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (act_o() !== {21'h0, 12'h0, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL reset_out got %h want 0", act_o());
    end
    n_checks++;
    if (imem_addr !== 12'h000 || imem_addr_w !== 12'hFFE) begin
      n_errors++;
      $display("FAIL reset_addr got %h/%h want 000/ffe",
               imem_addr, imem_addr_w);
    end
  endtask

  task automatic test_free_run();
    logic [34:0] want;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive_cycle(0, 0, 0, 12'h0);
      want = (k < 2) ? 35'h0 :
             {9'h0, 12'(k-2), 12'(k-2), 1'b1, 1'b0};
      n_checks++;
      if (act_o() !== want || act_o() !== exp_o()) begin
        n_errors++;
        $display("FAIL free_run k=%0d got %h want %h",
                 k, act_o(), want);
      end
      n_checks++;
      if (a_addr !== e_addr) begin
        n_errors++;
        $display("FAIL free_run_addr k=%0d got %h want %h",
                 k, a_addr, e_addr);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    for (int k = 1; k <= 7; k++) drive_cycle(0, 0, 0, 12'h0);
    for (int k = 0; k < 3; k++) begin
      drive_cycle(1, 0, 0, 12'h0);
      n_checks++;
      if (fi.PC !== 12'h005 || fi.Instruction !== 21'h5
          || fi.valid !== 1'b1 || a_addr !== 12'h006) begin
        n_errors++;
        $display("FAIL stall_hold k=%0d got pc %h addr %h want 005/006",
                 k, fi.PC, a_addr);
      end
    end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, 0, 0, 12'h0);
      n_checks++;
      if (fi.PC !== 12'(6 + k) || fi.valid !== 1'b1
          || act_o() !== exp_o()) begin
        n_errors++;
        $display("FAIL stall_release k=%0d got %h want pc %0d",
                 k, act_o(), 6 + k);
      end
    end
  endtask

  task automatic test_branch(input logic with_stall,
                             input logic [11:0] tgt, input int lead);
    do_reset();
    for (int k = 1; k <= lead; k++) drive_cycle(0, 0, 0, 12'h0);
    drive_cycle(with_stall, 0, 1, tgt);
    drive_cycle(0, 0, 0, 12'h0);
    n_checks++;
    if (fi.valid !== 1'b0 || fi.Instruction !== 21'h0) begin
      n_errors++;
      $display("FAIL branch_bubble st=%0b got %h want bubble",
               with_stall, act_o());
    end
    for (int k = 0; k < 2; k++) begin
      drive_cycle(0, 0, 0, 12'h0);
      n_checks++;
      if (fi.PC !== tgt + 12'(k) || fi.valid !== 1'b1
          || act_o() !== exp_o()) begin
        n_errors++;
        $display("FAIL branch_target st=%0b got %h want pc %h",
                 with_stall, act_o(), tgt + 12'(k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [11:0] seq [4];
    seq[0] = 12'hFFE; seq[1] = 12'hFFF;
    seq[2] = 12'h000; seq[3] = 12'h001;
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      drive_cycle(0, 0, 0, 12'h0);
      if (k >= 2) begin
        n_checks++;
        if (fw.PC !== seq[k-2] || fw.valid !== 1'b1
            || fw.Instruction !== {9'h0, seq[k-2]}) begin
          n_errors++;
          $display("FAIL wrap k=%0d got pc %h want %h",
                   k, fw.PC, seq[k-2]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 1; k <= 4; k++) drive_cycle(0, 0, 0, 12'h0);
    fi.stall = 1'b1; fi.branch_taken = 1'b1; fi.BranchAddr = 12'h123;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (act_o() !== 35'h0 || imem_addr !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_mid got %h addr %h want 0/000",
               act_o(), imem_addr);
    end
    @(negedge clk);
    fi.stall = 0; fi.branch_taken = 0;
    model_reset();
    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive_cycle(0, 0, 0, 12'h0);
      n_checks++;
      if (act_o() !== exp_o()) begin
        n_errors++;
        $display("FAIL reset_mid_restart k=%0d got %h want %h",
                 k, act_o(), exp_o());
      end
    end
  endtask

  task automatic test_random();
    logic st, fl, br;
    logic [11:0] ba;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      st = ($urandom_range(0, 99) < 25);
      fl = ($urandom_range(0, 99) < 8);
      br = ($urandom_range(0, 99) < 10);
      ba = ($urandom_range(0, 3) == 0) ? 12'hFFD + 12'($urandom_range(0, 3))
                                        : 12'($urandom);
      drive_cycle(st, fl, br, ba);
      n_checks++;
      if (act_o() !== exp_o() || a_addr !== e_addr) begin
        n_errors++;
        $display("FAIL random k=%0d got %h/%h want %h/%h",
                 k, act_o(), a_addr, exp_o(), e_addr);
      end
    end
  endtask

`ifdef FETCH_HALT_EN
  task automatic test_halt();
    rom_halt = 1'b1; halt_at = 12'h003;
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      drive_cycle(0, 0, k == 8, 12'h055);
      n_checks++;
      if (act_o() !== exp_o()
          || (k == 5 && (fi.PC !== 12'h003 || fi.valid !== 1'b1))
          || (k >= 5 && fi.halted !== 1'b1)
          || (k >= 6 && fi.valid !== 1'b0)) begin
        n_errors++;
        $display("FAIL halt k=%0d got %h want %h", k, act_o(), exp_o());
      end
    end
    do_reset();
    for (int k = 1; k <= 2; k++) drive_cycle(0, 0, 0, 12'h0);
    n_checks++;
    if (fi.halted !== 1'b0 || fi.PC !== 12'h000 || fi.valid !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_restart got %h want pc 000 valid", act_o());
    end
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      drive_cycle(0, 0, k == 5, 12'h020);
      n_checks++;
      if (act_o() !== exp_o() || fi.halted !== 1'b0
          || (k == 7 && fi.PC !== 12'h020)) begin
        n_errors++;
        $display("FAIL halt_suppress k=%0d got %h want %h",
                 k, act_o(), exp_o());
      end
    end
    rom_halt = 1'b0;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_free_run();
    test_stall();
    test_branch(1'b0, 12'h040, 10);
    test_branch(1'b1, 12'h010, 6);
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef FETCH_HALT_EN
    test_halt();
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end
endmodule
